// File: rtl/alu_matrix_loader_if.sv
// Element-stream input and finished-matrix output of the 5x5 matrix loader.
// The slave view belongs to the loader; the master view is the producer/consumer side.
interface alu_matrix_loader_if #(
  parameter int DATA_W = 8,
  parameter int N      = 5
);
  logic [DATA_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*N*DATA_W-1:0] mat_flat;
  logic                  mat_valid;
  logic                  mat_ready;

  modport slave (
    input  in_data, in_valid, mat_ready,
    output in_ready, mat_flat, mat_valid
  );

  modport master (
    output in_data, in_valid, mat_ready,
    input  in_ready, mat_flat, mat_valid
  );
endinterface

// File: rtl/alu_matrix_loader.sv
// Assembles an NxN matrix from a row-major element stream, optionally transposing
// on load, and holds the flattened result until the consumer takes it.
module alu_matrix_loader #(
  parameter int DATA_W = 8,
  parameter int N      = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                transpose_en,
  input  logic                abort,
  alu_matrix_loader_if.slave  bus,
  output logic                busy,
  output logic [4:0]          count,
  output logic                err_flag
);

  localparam int IW = $clog2(N*N);
  localparam int RW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t                state, state_nxt;
  logic [N*N*DATA_W-1:0] flat;
  logic [RW-1:0]         row, col;
  logic                  xpose;
  logic                  ready;
  logic                  accept;
  logic                  last_beat;
  logic [IW-1:0]         slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        ready = !abort;
        if (abort)                  state_nxt = IDLE;
        else if (accept && last_beat) state_nxt = HOLD;
      end
      HOLD: if (abort || bus.mat_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = bus.in_valid && ready;
  assign last_beat = (count == 5'(N*N-1));
  // Row/column counters stand in for p/N and p%N; transpose just swaps their roles.
  assign slot      = xpose ? (IW'(col) * IW'(N) + IW'(row))
                           : (IW'(row) * IW'(N) + IW'(col));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flat     <= '0;
      count    <= '0;
      row      <= '0;
      col      <= '0;
      xpose    <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      if (start && state != IDLE) err_flag <= 1'b1;
      case (state)
        IDLE: if (start) begin
          flat     <= '0;
          count    <= '0;
          row      <= '0;
          col      <= '0;
          xpose    <= transpose_en;
          err_flag <= 1'b0;
        end
        LOAD, HOLD: begin
          if (abort) begin
            flat  <= '0;
            count <= '0;
            row   <= '0;
            col   <= '0;
          end else if (accept) begin
            for (int k = 0; k < N*N; k++)
              if (slot == IW'(k)) flat[k*DATA_W +: DATA_W] <= bus.in_data;
            count <= count + 5'd1;
            if (col == RW'(N-1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mat_valid = (state == HOLD);
  assign bus.mat_flat  = flat;
  assign busy          = (state != IDLE);

endmodule
